ascii_num_parser: RTL and testbench

Streaming ASCII-to-binary number parser: the parametrised successor of the team's fixed-width decimal ASCII-to-binary converter. It accepts one ASCII character per cycle over a valid/ready stream with an explicit end-of-number marker, accumulates decimal or hexadecimal digits with an optional leading sign, and emits one binary result per number on a valid/ready output. It sits between the UART/command-byte front end and the register/command decoder, and flags malformed input and range overflow instead of silently producing garbage.

---
 rtl/ascii_num_parser.sv | 176 +++++++++++++++++
 tb/tb_ascii_num_parser.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_num_parser.sv
// Streaming ASCII decimal/hex number parser with optional sign.
// One character per beat in, one binary result per number out.
module ascii_num_parser #(
    parameter int MAX_DIGITS = 10,
    parameter int OUT_W      = 32,
    parameter bit SIGNED_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    input  logic             mode_hex,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_err,
    output logic             m_ovf,
    output logic             busy
);

    localparam int AW = OUT_W + 5;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    localparam logic [AW-1:0] ONE   = AW'(1);
    localparam logic [AW-1:0] LIM_U = (ONE << OUT_W) - ONE;
    localparam logic [AW-1:0] LIM_P = (ONE << (OUT_W - 1)) - ONE;
    localparam logic [AW-1:0] LIM_N = ONE << (OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hex_q, hex_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;

    logic            first;
    logic            beat;
    logic            c_hex;
    logic            c_neg;
    logic [AW-1:0]   c_acc;
    logic            is_dig;
    logic            is_sign;
    logic [3:0]      dig;
    logic [AW-1:0]   mul;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   lim;
    logic            bad;
    logic [OUT_W-1:0] mag;

    assign first = (state_q == IDLE);
    assign beat  = s_valid && s_ready;

    // On the first beat the stored context is stale; use cleared values.
    assign c_hex = first ? mode_hex : hex_q;
    assign c_neg = first ? 1'b0 : neg_q;
    assign c_acc = first ? '0 : acc_q;

    assign is_sign = first && SIGNED_EN &&
                     (s_data == 8'h2D || s_data == 8'h2B);

    always_comb begin
        is_dig = 1'b0;
        dig    = '0;
        unique case (1'b1)
            (s_data >= 8'h30 && s_data <= 8'h39): begin
                is_dig = 1'b1;
                dig    = 4'(s_data - 8'h30);
            end
            (c_hex && s_data >= 8'h61 && s_data <= 8'h66): begin
                is_dig = 1'b1;
                dig    = 4'(s_data - 8'h57);
            end
            (c_hex && s_data >= 8'h41 && s_data <= 8'h46): begin
                is_dig = 1'b1;
                dig    = 4'(s_data - 8'h37);
            end
            default: ;
        endcase
    end

    assign mul = c_hex ? (c_acc << 4)
                       : ((c_acc << 3) + (c_acc << 1));
    assign sum = mul + AW'(dig);
    assign lim = c_neg     ? LIM_N :
                 SIGNED_EN ? LIM_P : LIM_U;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        neg_d   = neg_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (beat) begin
                    acc_d = c_acc;
                    hex_d = c_hex;
                    neg_d = c_neg;
                    err_d = first ? 1'b0 : err_q;
                    ovf_d = first ? 1'b0 : ovf_q;
                    cnt_d = first ? '0 : cnt_q;
                    if (is_sign) begin
                        neg_d = (s_data == 8'h2D);
                    end else if (is_dig) begin
                        // Count saturates at MAX_DIGITS; any digit past it is an error.
                        if (cnt_d == CW'(MAX_DIGITS))
                            err_d = 1'b1;
                        else
                            cnt_d = cnt_d + 1'b1;
                        if (!ovf_d) begin
                            if (sum > lim)
                                ovf_d = 1'b1;
                            else
                                acc_d = sum;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = s_last ? OUTPUT : ACCUM;
                end
            end
            OUTPUT: begin
                if (m_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            hex_q   <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s_ready = (state_q != OUTPUT);
    assign m_valid = (state_q == OUTPUT);
    assign busy    = (state_q != IDLE);

    assign bad   = err_q || (cnt_q == '0);
    assign mag   = acc_q[OUT_W-1:0];
    assign m_err = m_valid && bad;
    assign m_ovf = m_valid && ovf_q;

    always_comb begin
        m_data = '0;
        if (m_valid && !bad && !ovf_q)
            m_data = neg_q ? (~mag + 1'b1) : mag;
    end

endmodule

// File: tb/tb_ascii_num_parser.sv
// Randomised bench for ascii_num_parser against a string-level reference model.
// Directed cases cover latency, backpressure and mid-number reset.
module tb_ascii_num_parser;

    localparam int OUT_W = 32;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] d;
        logic        e;
        logic        o;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       s_data = '0;
    logic             s_last = 1'b0;
    logic             mode_hex = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [OUT_W-1:0] m_data;
    logic             m_err;
    logic             m_ovf;
    logic             busy;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    acc_edge = 0;
    int    hs_edge = 0;
    bit    rand_rdy = 1'b0;
    bit    hold_p = 1'b0;
    logic [33:0] hold_v;
    exp_t  exp_q[$];
    exp_t  e_mon;

    ascii_num_parser dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .mode_hex (mode_hex),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_err    (m_err),
        .m_ovf    (m_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(bq_t s, bit hex);
        exp_t r;
        longint unsigned acc = 0;
        longint unsigned lim;
        longint unsigned t;
        bit neg = 0;
        int cnt = 0;
        int d;
        int base = hex ? 16 : 10;
        r.e = 0;
        r.o = 0;
        foreach (s[i]) begin
            d = -1;
            if (s[i] >= "0" && s[i] <= "9") d = int'(s[i]) - 48;
            else if (hex && s[i] >= "a" && s[i] <= "f") d = int'(s[i]) - 87;
            else if (hex && s[i] >= "A" && s[i] <= "F") d = int'(s[i]) - 55;
            if (i == 0 && (s[i] == "-" || s[i] == "+")) begin
                if (s[i] == "-") neg = 1;
            end else if (d >= 0) begin
                if (cnt >= 10) r.e = 1;
                cnt++;
                lim = neg ? 64'd2147483648 : 64'd2147483647;
                if (!r.o) begin
                    t = acc * longint'(base) + longint'(d);
                    if (t > lim) r.o = 1;
                    else acc = t;
                end
            end else begin
                r.e = 1;
            end
        end
        if (cnt == 0) r.e = 1;
        if (r.e || r.o) r.d = 0;
        else r.d = neg ? 32'(-acc) : 32'(acc);
        return r;
    endfunction

    function automatic bq_t str2q(string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic push(logic [31:0] d, logic e, logic o);
        exp_t x;
        x.d = d;
        x.e = e;
        x.o = o;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(logic [7:0] c, bit last, bit hex, bit first);
        int n = 0;
        bit rdy;
        s_valid  = 1'b1;
        s_data   = c;
        s_last   = last;
        mode_hex = first ? hex : 1'($urandom);
        forever begin
            rdy = s_ready;
            tick();
            if (rdy) break;
            n++;
            if (n > 300) begin
                chk("beat_timeout", 1, 0);
                break;
            end
        end
        s_valid  = 1'b0;
        s_last   = 1'b0;
        acc_edge = cyc;
    endtask

    task automatic send(bq_t s, bit hex, int gap_max);
        foreach (s[i]) begin
            beat(s[i], i == s.size() - 1, hex, i == 0);
            if (gap_max > 0)
                repeat ($urandom_range(gap_max, 0)) tick();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        tick();
    endtask

    function automatic bq_t gen(output bit hex);
        bq_t q;
        int len;
        int r;
        string bad = "x g.";
        hex = 1'($urandom);
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 99);
            if (i == 0 && r < 15)
                q.push_back(r < 10 ? 8'h2D : 8'h2B);
            else if (r < 72)
                q.push_back(8'(48 + $urandom_range(0, 9)));
            else if (r < 84)
                q.push_back(8'($urandom_range(0, 1) ? 97 : 65)
                            + 8'($urandom_range(0, 5)));
            else if (r < 88)
                q.push_back(8'h2D);
            else if (r < 90)
                q.push_back(8'h2B);
            else
                q.push_back(bad[$urandom_range(0, 3)]);
        end
        return q;
    endfunction

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            m_ready = ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("s_ready_vs_m_valid", s_ready, !m_valid);
            if (m_valid) begin
                if (hold_p)
                    chk("hold_stable", {m_data, m_err, m_ovf}, hold_v);
                if (m_ready) begin
                    hs_edge = cyc + 1;
                    hold_p  = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e_mon = exp_q.pop_front();
                        chk("m_data", m_data, e_mon.d);
                        chk("m_err", m_err, e_mon.e);
                        chk("m_ovf", m_ovf, e_mon.o);
                    end
                end else begin
                    hold_p = 1'b1;
                    hold_v = {m_data, m_err, m_ovf};
                end
            end else begin
                hold_p = 1'b0;
            end
        end else begin
            hold_p = 1'b0;
        end
    end

    initial begin
        bq_t q;
        bit  hx;
        int  t0;

        repeat (3) tick();
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_m_ovf", m_ovf, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        m_ready = 1'b1;
        push(32'h4D2, 0, 0);
        t0 = cyc;
        send(str2q("1234"), 0, 0);
        chk("beats_4_cycles", cyc - t0, 4);
        chk("latency_m_valid", m_valid, 1);
        chk("busy_in_output", busy, 1);
        chk("s_ready_low_out", s_ready, 0);
        drain();

        push(32'hFFFFFFD6, 0, 0);
        send(str2q("-42"), 0, 0);
        push(32'h80000000, 0, 0);
        send(str2q("-2147483648"), 0, 0);
        push(32'h0, 0, 1);
        send(str2q("2147483648"), 0, 0);
        push(32'hFF, 0, 0);
        send(str2q("fF"), 1, 0);
        push(32'h0, 1, 0);
        send(str2q("fF"), 0, 0);
        push(32'h1A, 0, 0);
        send(str2q("1a"), 1, 0);
        push(32'h0, 1, 0);
        send(str2q("12a3"), 0, 0);
        push(32'h0, 1, 0);
        send(str2q("-"), 0, 0);
        push(32'h0, 1, 1);
        send(str2q("12345678901"), 0, 0);
        drain();

        m_ready = 1'b0;
        push(32'h7, 0, 0);
        send(str2q("7"), 0, 0);
        fork
            begin
                repeat (5) begin
                    chk("bp_m_valid", m_valid, 1);
                    chk("bp_m_data", m_data, 7);
                    chk("bp_s_ready", s_ready, 0);
                    tick();
                end
                m_ready = 1'b1;
            end
            begin
                push(32'h5, 0, 0);
                send(str2q("5"), 0, 0);
            end
        join
        chk("bp_accept_edge", acc_edge, hs_edge + 1);
        drain();

        beat("9", 0, 0, 1);
        chk("busy_after_first", busy, 1);
        beat("8", 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        push(32'h5, 0, 0);
        send(str2q("5"), 0, 0);
        drain();

        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            q = gen(hx);
            exp_q.push_back(model(q, hx));
            send(q, hx, 2);
        end
        drain();
        rand_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
